// File: rtl/ysyx_22050058_wb_stage_pkg.sv
// Shared write-back stage definitions: core bus widths, WB state encodings,
// load funct3 codes and the ebreak instruction word.
package ysyx_22050058_wb_stage_pkg;

  localparam int REG_BUS  = 64;
  localparam int REG_ADDR = 5;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  typedef enum logic [1:0] {
    WB_IDLE      = 2'd0,
    WB_WAIT_LOAD = 2'd1,
    WB_COMMIT    = 2'd2,
    WB_HALT      = 2'd3
  } wb_state_e;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LD  = 3'd3;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_LWU = 3'd6;

  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

endpackage

// File: rtl/ysyx_22050058_wb_stage_load_fmt.sv
// Load data formatter: picks the addressed bytes out of an aligned doubleword
// and sign/zero-extends them according to the load funct3. Purely combinational.
module ysyx_22050058_load_fmt
  import ysyx_22050058_wb_stage_pkg::*;
(
  input  logic [REG_BUS-1:0] rdata_i,
  input  logic [2:0]         addr_lo_i,
  input  logic [2:0]         funct3_i,
  output logic [REG_BUS-1:0] data_o
);

  logic [REG_BUS-1:0] shifted;

  // Bring the addressed byte down to bit 0; wide loads at odd offsets simply
  // see zeros shifted in from the top.
  always_comb begin
    shifted = rdata_i >> {addr_lo_i, 3'b000};
  end

  // Width selection and extension.
  always_comb begin
    data_o = '0;
    case (funct3_i)
      F3_LB:   data_o = {{56{shifted[7]}},  shifted[7:0]};
      F3_LH:   data_o = {{48{shifted[15]}}, shifted[15:0]};
      F3_LW:   data_o = {{32{shifted[31]}}, shifted[31:0]};
      F3_LD:   data_o = shifted;
      F3_LBU:  data_o = {56'd0, shifted[7:0]};
      F3_LHU:  data_o = {48'd0, shifted[15:0]};
      F3_LWU:  data_o = {32'd0, shifted[31:0]};
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/ysyx_22050058_wb_stage.sv
// Write-back stage: holds one retiring instruction, waits for load data when
// needed and drives the register-file write port for one cycle per retire.
// Optional retire counter output instret_o enabled by YSYX_22050058_RETIRE_CNT_EN.
//
// state        | meaning
// -------------+-----------------------------------------------
// WB_IDLE      | nothing held
// WB_WAIT_LOAD | load accepted, waiting for dmem_rvalid_i
// WB_COMMIT    | write port / commit pulse driven this cycle
// WB_HALT      | ebreak retired, stage frozen until rst
module ysyx_22050058_wb_stage
  import ysyx_22050058_wb_stage_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_valid_i,
  output logic                mem_ready_o,
  input  logic [REG_BUS-1:0]  mem_pc_i,
  input  logic [31:0]         mem_inst_i,
  input  logic                mem_rd_we_i,
  input  logic [REG_ADDR-1:0] mem_rd_i,
  input  logic                mem_is_load_i,
  input  logic [2:0]          mem_ld_funct3_i,
  input  logic [2:0]          mem_addr_lo_i,
  input  logic [REG_BUS-1:0]  mem_alu_res_i,
  input  logic                dmem_rvalid_i,
  input  logic [REG_BUS-1:0]  dmem_rdata_i,
  output logic                we_o,
  output logic [REG_ADDR-1:0] waddr_o,
  output logic [REG_BUS-1:0]  wdata_o,
  output logic                commit_o,
  output logic [REG_BUS-1:0]  commit_pc_o,
  output logic                halt_o
`ifdef YSYX_22050058_RETIRE_CNT_EN
  ,
  output logic [63:0]         instret_o
`endif
);

  wb_state_e           state_q, state_d;
  logic [REG_BUS-1:0]  pc_q, pc_d;
  logic [31:0]         inst_q, inst_d;
  logic [REG_ADDR-1:0] rd_q, rd_d;
  logic                rd_we_q, rd_we_d;
  logic [2:0]          funct3_q, funct3_d;
  logic [2:0]          addr_lo_q, addr_lo_d;
  logic [REG_BUS-1:0]  res_q, res_d;

  logic                we_q, we_d;
  logic [REG_ADDR-1:0] waddr_q, waddr_d;
  logic [REG_BUS-1:0]  wdata_q, wdata_d;
  logic                commit_q, commit_d;
  logic [REG_BUS-1:0]  commit_pc_q, commit_pc_d;
  logic                halt_q, halt_d;

  logic                held_ebreak;
  logic                ready;
  logic                accept;
  logic                in_commit;
  logic [REG_BUS-1:0]  fmt_data;

  ysyx_22050058_load_fmt u_load_fmt (
    .rdata_i   (dmem_rdata_i),
    .addr_lo_i (addr_lo_q),
    .funct3_i  (funct3_q),
    .data_o    (fmt_data)
  );

  // Handshake: a held ebreak blocks further accepts so nothing follows it.
  always_comb begin
    held_ebreak = (inst_q == INST_EBREAK);
    ready       = !rst && ((state_q == WB_IDLE) ||
                           ((state_q == WB_COMMIT) && !held_ebreak));
    accept      = mem_valid_i && ready;
  end

  assign mem_ready_o = ready;

  // Next state, held instruction and registered output values.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    rd_d      = rd_q;
    rd_we_d   = rd_we_q;
    funct3_d  = funct3_q;
    addr_lo_d = addr_lo_q;
    res_d     = res_q;

    case (state_q)
      WB_IDLE:      state_d = WB_IDLE;
      WB_WAIT_LOAD: begin
        if (dmem_rvalid_i) begin
          res_d   = fmt_data;
          state_d = WB_COMMIT;
        end
      end
      WB_COMMIT:    state_d = held_ebreak ? WB_HALT : WB_IDLE;
      WB_HALT:      state_d = WB_HALT;
      default:      state_d = WB_IDLE;
    endcase

    // A new beat can only arrive in IDLE or a non-ebreak COMMIT; it overrides
    // the fall-back to IDLE chosen above.
    if (accept) begin
      pc_d      = mem_pc_i;
      inst_d    = mem_inst_i;
      rd_d      = mem_rd_i;
      rd_we_d   = mem_rd_we_i;
      funct3_d  = mem_ld_funct3_i;
      addr_lo_d = mem_addr_lo_i;
      res_d     = mem_alu_res_i;
      state_d   = mem_is_load_i ? WB_WAIT_LOAD : WB_COMMIT;
    end

    in_commit   = (state_d == WB_COMMIT);
    we_d        = in_commit && rd_we_d && (rd_d != '0);
    waddr_d     = in_commit ? rd_d : '0;
    wdata_d     = in_commit ? res_d : '0;
    commit_d    = in_commit;
    commit_pc_d = in_commit ? pc_d : '0;
    halt_d      = (state_d == WB_HALT);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= WB_IDLE;
      pc_q        <= '0;
      inst_q      <= '0;
      rd_q        <= '0;
      rd_we_q     <= DISABLE;
      funct3_q    <= '0;
      addr_lo_q   <= '0;
      res_q       <= '0;
      we_q        <= DISABLE;
      waddr_q     <= '0;
      wdata_q     <= '0;
      commit_q    <= DISABLE;
      commit_pc_q <= '0;
      halt_q      <= DISABLE;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      rd_q        <= rd_d;
      rd_we_q     <= rd_we_d;
      funct3_q    <= funct3_d;
      addr_lo_q   <= addr_lo_d;
      res_q       <= res_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      commit_q    <= commit_d;
      commit_pc_q <= commit_pc_d;
      halt_q      <= halt_d;
    end
  end

  assign we_o        = we_q;
  assign waddr_o     = waddr_q;
  assign wdata_o     = wdata_q;
  assign commit_o    = commit_q;
  assign commit_pc_o = commit_pc_q;
  assign halt_o      = halt_q;

`ifdef YSYX_22050058_RETIRE_CNT_EN
  logic [63:0] instret_q, instret_d;

  // Count every COMMIT cycle; wraps naturally at 2^64.
  always_comb begin
    instret_d = instret_q + {63'd0, (state_q == WB_COMMIT)};
  end

  // Retire counter register.
  always_ff @(posedge clk) begin
    if (rst) instret_q <= '0;
    else     instret_q <= instret_d;
  end

  assign instret_o = instret_q;
`endif

endmodule

// File: doc/ysyx_22050058_wb_stage.md
# ysyx_22050058_wb_stage

Write-back stage of the ysyx_22050058 RV64 core, directly upstream of the general-purpose register file. It accepts one retiring instruction per handshake from the memory stage and waits for load data from the data-memory port when needed. It formats load data by width and sign, then drives the register-file write port (`we`/`waddr`/`wdata`) for exactly one cycle per retired instruction. It also detects `ebreak` and halts the core.

## Interface
Parameters: none. Widths come from the shared core defines: register bus 64, register address 5.

- clk  in  1  core clock
- rst  in  1  reset; **synchronous, active-high**
- mem_valid_i  in  1  memory stage presents an instruction
- mem_ready_o  out  1  stage can accept this cycle
- mem_pc_i  in  64  instruction PC
- mem_inst_i  in  32  instruction word
- mem_rd_we_i  in  1  instruction writes rd
- mem_rd_i  in  5  destination register
- mem_is_load_i  in  1  result comes from data memory
- mem_ld_funct3_i  in  3  load funct3 (LB..LWU)
- mem_addr_lo_i  in  3  load address bits [2:0]
- mem_alu_res_i  in  64  result for non-loads
- dmem_rvalid_i  in  1  load data valid
- dmem_rdata_i  in  64  aligned doubleword from data memory
- we_o  out  1  register-file write enable
- waddr_o  out  5  register-file write address
- wdata_o  out  64  register-file write data
- commit_o  out  1  one-cycle retire pulse
- commit_pc_o  out  64  PC of the retiring instruction
- halt_o  out  1  core halted by ebreak (sticky)

## Operation
- **States:**
  - IDLE: no held instruction.
  - WAIT_LOAD: load accepted; waiting for data.
  - COMMIT: `we_o`/`commit_o` asserted.
  - HALT: ebreak has retired.
- **Accept:** a beat is accepted when `mem_valid_i && mem_ready_o`. The stage latches pc, inst, rd, rd_we, funct3, addr_lo and alu_res.
- **Transitions:**
  - Non-load accepted → COMMIT.
  - Load accepted → WAIT_LOAD.
  - WAIT_LOAD with `dmem_rvalid_i` → COMMIT; the formatted data is captured.
  - COMMIT with a new accept → COMMIT or WAIT_LOAD, per the new beat.
  - COMMIT without an accept → IDLE.
  - COMMIT of ebreak (inst == 32'h0010_0073) → HALT.
  - HALT → HALT until rst.
- **mem_ready_o:** `(state==IDLE) || (state==COMMIT && !held_is_ebreak)`. It is 0 in WAIT_LOAD and in HALT.
- **Write port in COMMIT:**
  - `we_o = held_rd_we && held_rd != 0`.
  - `waddr_o = held_rd`.
  - `wdata_o` = formatted load data or held alu_res.
- **Outside COMMIT:** `we_o = 0`, `waddr_o = 0`, `wdata_o = 0`.
- **Commit outputs:** `commit_o = 1` in every COMMIT cycle, including rd=0 and non-writing instructions. `commit_pc_o` = held pc in COMMIT, otherwise 0.
- **Load formatting:**
  - Shift `dmem_rdata_i` right by addr_lo×8; vacated bits fill with 0.
  - LB/LH/LW sign-extend from bit 7/15/31.
  - LBU/LHU/LWU zero-extend.
  - LD takes the shifted value unchanged.
  - funct3 = 7 yields 0.
  - Misalignment is not checked: a wide load at a nonzero offset returns the zero-filled shifted value.
- `dmem_rvalid_i` outside WAIT_LOAD is ignored.
- **Reset** (including mid-load or in HALT):
  - Next state is IDLE and any held instruction is dropped.
  - All outputs read 0 in the cycle after reset is sampled, including `mem_ready_o` (0 while `rst` is high) and `halt_o`.

## Timing
- Non-load accepted in cycle N: `we_o`/`commit_o` high in N+1. The register file writes at the end of N+1, and its same-cycle bypass serves readers during N+1.
- Throughput: one non-load per cycle, with no bubble.
- Load accepted in N, `dmem_rvalid_i` first seen in cycle M ≥ N+1: COMMIT in M+1. Minimum load latency is 2 cycles.
- `halt_o` rises in the cycle after the ebreak COMMIT and stays high until reset.

## Configuration
- `YSYX_22050058_RETIRE_CNT_EN` defined:
  - Adds output `instret_o` [63:0], a counter incremented by 1 in every COMMIT cycle.
  - The counter resets to 0 and wraps modulo 2^64.
- Macro undefined: the port and the counter are absent; all other behaviour is identical.

## Structure
- Shared defines/package holds:
  - WB state encodings.
  - Load funct3 codes (LB=0, LH=1, LW=2, LD=3, LBU=4, LHU=5, LWU=6).
  - The EBREAK encoding.
  - Reuse of the existing register bus, address-width and enable constants.
- One combinational sub-module, `ysyx_22050058_load_fmt`: (rdata, addr_lo, funct3) → 64-bit result. It is testable standalone.

## Test plan
- Back-to-back non-loads: rd=5 res 0x11, then rd=6 res 0x22 in consecutive cycles → `we_o` high two consecutive cycles, `waddr_o` 5 then 6, `wdata_o` 0x11 then 0x22; `mem_ready_o` stays 1.
- LB at offset 3, rdata 0x0000_0000_8000_0000, `rvalid` 4 cycles after accept:
  - `mem_ready_o` is 0 while waiting.
  - `wdata_o` = 0xFFFF_FFFF_FFFF_FF80, `we_o` high the cycle after `rvalid`.
- LWU at offset 4, rdata 0xDEAD_BEEF_0000_0000 → `wdata_o` = 0x0000_0000_DEAD_BEEF.
- rd=0 with rd_we=1 → `commit_o`=1 and `we_o`=0.
- ebreak → one `commit_o` pulse; `halt_o`=1 from the next cycle; `mem_ready_o` stays 0 with `mem_valid_i` held high; `rst` clears all outputs to 0.
- `rst` asserted in WAIT_LOAD, then `rvalid` arrives → no write, no commit; the next beat is accepted normally. With `YSYX_22050058_RETIRE_CNT_EN` defined, `instret_o` counts only completed commits.
